// File: rtl/params_pkg.sv
// Shared trap-controller definitions: trap report payload, exception codes,
// mtvec mode encodings and the trap_ctrl FSM state encodings.
package params_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned CAUSE_W     = 31;
  localparam int unsigned STATE_W     = 3;
  localparam int unsigned FLUSH_CNT_W = 4;

  // Trap report from writeback; pc/insn identify the trapping instruction.
  typedef struct packed {
    logic               valid;
    logic               is_interrupt;
    logic [CAUSE_W-1:0] mcause;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    insn;
  } trap_info_t;

  localparam logic [CAUSE_W-1:0] TRAP_CODE_INSN_MISALIGNED  = 31'd0;
  localparam logic [CAUSE_W-1:0] TRAP_CODE_INSN_FAULT       = 31'd1;
  localparam logic [CAUSE_W-1:0] TRAP_CODE_ILLEGAL_INSN     = 31'd2;
  localparam logic [CAUSE_W-1:0] TRAP_CODE_BREAKPOINT       = 31'd3;
  localparam logic [CAUSE_W-1:0] TRAP_CODE_LOAD_MISALIGNED  = 31'd4;
  localparam logic [CAUSE_W-1:0] TRAP_CODE_LOAD_FAULT       = 31'd5;
  localparam logic [CAUSE_W-1:0] TRAP_CODE_STORE_MISALIGNED = 31'd6;
  localparam logic [CAUSE_W-1:0] TRAP_CODE_STORE_FAULT      = 31'd7;
  localparam logic [CAUSE_W-1:0] TRAP_CODE_ECALL_M          = 31'd11;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  // trap_ctrl FSM state encodings
  localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] ST_FLUSH      = 3'd1;
  localparam logic [STATE_W-1:0] ST_SAVE       = 3'd2;
  localparam logic [STATE_W-1:0] ST_REDIRECT   = 3'd3;
  localparam logic [STATE_W-1:0] ST_MRET_FLUSH = 3'd4;

endpackage

// File: rtl/trap_ctrl.sv
// Trap / mret sequencer: flushes the pipeline, saves mepc/mcause/mtval,
// updates mstatus and redirects fetch to the trap handler or mepc.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   trap_i, trap_addr_i      trap report + faulting address from writeback
//   mret_i                   mret retiring in writeback
//   mtvec_i, mepc_i          current CSR values
//   flush_o, busy_o          pipeline kill / fetch stall
//   csr_trap_wr_o + *_wdata_o  one-cycle CSR save strobe and data
//   mstatus_trap_o/_mret_o   mstatus update strobes
//   redirect_valid_o/_pc_o/_ready_i  PC redirect handshake to fetch
module trap_ctrl
  import params_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  trap_info_t      trap_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            flush_o,
  output logic            busy_o,
  output logic            csr_trap_wr_o,
  output logic [XLEN-1:0] mepc_wdata_o,
  output logic [XLEN-1:0] mcause_wdata_o,
  output logic [XLEN-1:0] mtval_wdata_o,
  output logic            mstatus_trap_o,
  output logic            mstatus_mret_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i
);

  localparam logic [FLUSH_CNT_W-1:0] CNT_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  // Handler address: direct base, or base + 4*cause for vectored interrupts.
  function automatic logic [XLEN-1:0] trap_target(
    input logic [XLEN-1:0]    mtvec,
    input logic               is_int,
    input logic [CAUSE_W-1:0] cause
  );
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    if (is_int && (mtvec[1:0] == MTVEC_MODE_VECTORED))
      return base + XLEN'({cause, 2'b00});
    return base;
  endfunction

  logic [STATE_W-1:0]     state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   is_int_q, is_int_d;
  logic [CAUSE_W-1:0]     cause_q, cause_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        insn_q, insn_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic [XLEN-1:0]        tgt_q, tgt_d;

  logic            flush_d, busy_d, csr_wr_d, mst_trap_d, mst_mret_d, redir_valid_d;
  logic [XLEN-1:0] mepc_wd_d, mcause_wd_d, mtval_wd_d, redir_pc_d;

  // Next-state, capture and registered-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_int_d      = is_int_q;
    cause_d       = cause_q;
    pc_d          = pc_q;
    insn_d        = insn_q;
    addr_d        = addr_q;
    tgt_d         = tgt_q;
    mst_mret_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (trap_i.valid) begin
          is_int_d = trap_i.is_interrupt;
          cause_d  = trap_i.mcause;
          pc_d     = trap_i.pc;
          insn_d   = trap_i.insn;
          addr_d   = trap_addr_i;
          cnt_d    = CNT_INIT;
          state_d  = ST_FLUSH;
        end else if (mret_i) begin
          tgt_d    = mepc_i;
          cnt_d    = CNT_INIT;
          state_d  = ST_MRET_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_SAVE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      ST_MRET_FLUSH: begin
        if (cnt_q == '0) begin
          state_d    = ST_REDIRECT;
          mst_mret_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SAVE: begin
        tgt_d   = trap_target(mtvec_i, is_int_q, cause_q);
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    flush_d       = (state_d == ST_FLUSH) || (state_d == ST_MRET_FLUSH);
    busy_d        = (state_d != ST_IDLE);
    csr_wr_d      = (state_d == ST_SAVE);
    mst_trap_d    = (state_d == ST_SAVE);
    redir_valid_d = (state_d == ST_REDIRECT);
    redir_pc_d    = redir_valid_d ? tgt_d : '0;

    mepc_wd_d   = '0;
    mcause_wd_d = '0;
    mtval_wd_d  = '0;
    if (state_d == ST_SAVE) begin
      mepc_wd_d   = {pc_q[XLEN-1:2], 2'b00};
      mcause_wd_d = {is_int_q, cause_q};
      unique case (cause_q)
        TRAP_CODE_ILLEGAL_INSN:     mtval_wd_d = insn_q;
        TRAP_CODE_INSN_MISALIGNED,
        TRAP_CODE_LOAD_MISALIGNED,
        TRAP_CODE_STORE_MISALIGNED: mtval_wd_d = addr_q;
        default:                    mtval_wd_d = '0;
      endcase
    end
  end

  // State, capture and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      is_int_q         <= 1'b0;
      cause_q          <= '0;
      pc_q             <= '0;
      insn_q           <= '0;
      addr_q           <= '0;
      tgt_q            <= '0;
      flush_o          <= 1'b0;
      busy_o           <= 1'b0;
      csr_trap_wr_o    <= 1'b0;
      mepc_wdata_o     <= '0;
      mcause_wdata_o   <= '0;
      mtval_wdata_o    <= '0;
      mstatus_trap_o   <= 1'b0;
      mstatus_mret_o   <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      is_int_q         <= is_int_d;
      cause_q          <= cause_d;
      pc_q             <= pc_d;
      insn_q           <= insn_d;
      addr_q           <= addr_d;
      tgt_q            <= tgt_d;
      flush_o          <= flush_d;
      busy_o           <= busy_d;
      csr_trap_wr_o    <= csr_wr_d;
      mepc_wdata_o     <= mepc_wd_d;
      mcause_wdata_o   <= mcause_wd_d;
      mtval_wdata_o    <= mtval_wd_d;
      mstatus_trap_o   <= mst_trap_d;
      mstatus_mret_o   <= mst_mret_d;
      redirect_valid_o <= redir_valid_d;
      redirect_pc_o    <= redir_pc_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, reset corner
// sequences and randomized transactions against a reference model.
module tb_trap_ctrl;
  import params_pkg::*;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  trap_info_t  trap_i;
  logic [31:0] trap_addr_i, mtvec_i, mepc_i;
  logic        mret_i, redirect_ready_i;
  logic        flush_o, busy_o, csr_trap_wr_o, mstatus_trap_o, mstatus_mret_o, redirect_valid_o;
  logic [31:0] mepc_wdata_o, mcause_wdata_o, mtval_wdata_o, redirect_pc_o;

  always #5 clk = ~clk;

  trap_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk_i(clk), .rst_i(rst_i), .trap_i(trap_i), .trap_addr_i(trap_addr_i),
    .mret_i(mret_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .flush_o(flush_o), .busy_o(busy_o), .csr_trap_wr_o(csr_trap_wr_o),
    .mepc_wdata_o(mepc_wdata_o), .mcause_wdata_o(mcause_wdata_o),
    .mtval_wdata_o(mtval_wdata_o), .mstatus_trap_o(mstatus_trap_o),
    .mstatus_mret_o(mstatus_mret_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_trap;
    bit          is_int;
    logic [30:0] cause;
    logic [31:0] pc, insn, addr, mtvec;
    bit          mret;
    logic [31:0] mepc;
    logic [31:0] exp_mepc, exp_mcause, exp_mtval, exp_pc;
    int          delay;
  } vec_t;

  // Reference: expectations straight from the architectural rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    longint unsigned t;
    if (v.is_trap) begin
      r.exp_mepc   = v.pc - (v.pc % 4);
      r.exp_mcause = (v.is_int ? 32'h8000_0000 : 32'h0) + {1'b0, v.cause};
      if (v.cause == 2)                                  r.exp_mtval = v.insn;
      else if (v.cause == 0 || v.cause == 4 || v.cause == 6) r.exp_mtval = v.addr;
      else                                               r.exp_mtval = 0;
      t = (longint'(v.mtvec) / 4) * 4;
      if (v.is_int && (v.mtvec % 4 == 1)) t = t + longint'(v.cause) * 4;
      r.exp_pc = t[31:0];
    end else begin
      r.exp_pc = v.mepc;
    end
    return r;
  endfunction

  function automatic trap_info_t rand_trap();
    return trap_info_t'(97'({$urandom, $urandom, $urandom, $urandom}));
  endfunction

  task automatic drive_idle();
    trap_i = '0; trap_addr_i = '0; mret_i = 1'b0; mepc_i = '0; redirect_ready_i = 1'b0;
  endtask

  // Issue one trap/mret and follow it to completion, checking everything seen.
  task automatic run_txn(input vec_t v, input bit noise, input string tag);
    int n_flush = 0, n_csr = 0, n_mt = 0, n_mr = 0, n_valid = 0;
    int csr_cyc = -1, red_cyc = -1, mr_cyc = -1, wait_cnt = 0, busy_bad = 0, unstable = 0;
    bit done = 0, seen = 0;
    logic [31:0] red_pc = 0, g_mepc = 0, g_mcause = 0, g_mtval = 0;
    trap_i.valid = v.is_trap; trap_i.is_interrupt = v.is_int; trap_i.mcause = v.cause;
    trap_i.pc = v.pc; trap_i.insn = v.insn; trap_addr_i = v.addr;
    mret_i = v.mret; mepc_i = v.mepc; mtvec_i = v.mtvec;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (noise) begin
        trap_i = rand_trap(); trap_addr_i = $urandom; mret_i = 1'($urandom); mepc_i = $urandom;
      end else begin
        trap_i = '0; mret_i = 1'b0;
      end
      if (busy_o !== 1'b1) busy_bad++;
      if (flush_o) n_flush++;
      if (csr_trap_wr_o) begin
        n_csr++; csr_cyc = cyc;
        g_mepc = mepc_wdata_o; g_mcause = mcause_wdata_o; g_mtval = mtval_wdata_o;
      end
      if (mstatus_trap_o) n_mt++;
      if (mstatus_mret_o) begin n_mr++; mr_cyc = cyc; end
      if (redirect_valid_o) begin
        n_valid++;
        if (!seen) begin seen = 1; red_pc = redirect_pc_o; red_cyc = cyc; end
        else if (redirect_pc_o !== red_pc) unstable++;
        if (wait_cnt >= v.delay) begin redirect_ready_i = 1'b1; done = 1; end
        else wait_cnt++;
      end
      @(posedge clk); #1;
    end
    drive_idle();
    check({tag, " completes"}, 32'(done), 32'd1);
    check({tag, " flush cycles"}, 32'(n_flush), 32'(FC));
    check({tag, " csr_trap_wr pulses"}, 32'(n_csr), v.is_trap ? 32'd1 : 32'd0);
    check({tag, " mstatus_trap pulses"}, 32'(n_mt), v.is_trap ? 32'd1 : 32'd0);
    check({tag, " mstatus_mret pulses"}, 32'(n_mr), v.is_trap ? 32'd0 : 32'd1);
    if (v.is_trap) begin
      check({tag, " save cycle"}, 32'(csr_cyc), 32'(FC));
      check({tag, " redirect cycle"}, 32'(red_cyc), 32'(FC + 1));
      check({tag, " mepc"}, g_mepc, v.exp_mepc);
      check({tag, " mcause"}, g_mcause, v.exp_mcause);
      check({tag, " mtval"}, g_mtval, v.exp_mtval);
    end else begin
      check({tag, " mret pulse cycle"}, 32'(mr_cyc), 32'(FC));
      check({tag, " redirect cycle"}, 32'(red_cyc), 32'(FC));
    end
    check({tag, " redirect_pc"}, red_pc, v.exp_pc);
    check({tag, " redirect held cycles"}, 32'(n_valid), 32'(v.delay + 1));
    check({tag, " redirect_pc unstable"}, 32'(unstable), 32'd0);
    check({tag, " busy dropped while active"}, 32'(busy_bad), 32'd0);
    check({tag, " idle after ready"}, {30'd0, busy_o, redirect_valid_o}, 32'd0);
  endtask

  // Count any activity over n cycles with idle inputs.
  task automatic quiet_cycles(input int n, output int activity);
    activity = 0;
    for (int i = 0; i < n; i++) begin
      if (flush_o || busy_o || csr_trap_wr_o || mstatus_trap_o || mstatus_mret_o || redirect_valid_o)
        activity++;
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[8];
  vec_t rv;
  int act;
  int guard;

  initial begin
    // Directed table; expectations worked out by hand.
    vecs[0] = '{1, 0, 31'd2,  32'h0000_0104, 32'hFFFF_FFFF, 32'h0000_0055, 32'h0000_0200, 0, 32'h0,
                32'h0000_0104, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0200, 0};
    vecs[1] = '{1, 1, 31'd7,  32'h0000_1000, 32'h0000_0013, 32'h0000_0000, 32'h0000_0201, 0, 32'h0,
                32'h0000_1000, 32'h8000_0007, 32'h0000_0000, 32'h0000_021C, 1};
    vecs[2] = '{0, 0, 31'd0,  32'h0, 32'h0, 32'h0, 32'h0000_0200, 1, 32'h0000_0400,
                32'h0, 32'h0, 32'h0, 32'h0000_0400, 0};
    vecs[3] = '{1, 0, 31'd11, 32'h0000_2002, 32'h0000_0073, 32'h0000_0000, 32'h0000_0301, 1, 32'h0000_0800,
                32'h0000_2000, 32'h0000_000B, 32'h0000_0000, 32'h0000_0300, 5};
    vecs[4] = '{1, 0, 31'd4,  32'h0000_0080, 32'h0000_2003, 32'hDEAD_BEEF, 32'h0000_1000, 0, 32'h0,
                32'h0000_0080, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_1000, 2};
    vecs[5] = '{1, 0, 31'd0,  32'h0000_0003, 32'h0000_0000, 32'h0001_2345, 32'hFFFF_FFFD, 0, 32'h0,
                32'h0000_0000, 32'h0000_0000, 32'h0001_2345, 32'hFFFF_FFFC, 0};
    vecs[6] = '{1, 1, 31'h40, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FF01, 0, 32'h0,
                32'h0000_0010, 32'h8000_0040, 32'h0000_0000, 32'h0000_0000, 0};
    vecs[7] = '{1, 0, 31'd6,  32'h0000_0F0C, 32'h0000_0000, 32'hA5A5_A5A4, 32'h0000_0202, 0, 32'h0,
                32'h0000_0F0C, 32'h0000_0006, 32'hA5A5_A5A4, 32'h0000_0200, 3};

    // Reset, with a trap presented during reset that must not be taken.
    drive_idle(); mtvec_i = '0; rst_i = 1'b1;
    trap_i.valid = 1'b1; mret_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy/flush/valid", {29'd0, busy_o, flush_o, redirect_valid_o}, 32'd0);
    check("reset strobes", {29'd0, csr_trap_wr_o, mstatus_trap_o, mstatus_mret_o}, 32'd0);
    check("reset redirect_pc", redirect_pc_o, 32'd0);
    check("reset mepc_wdata", mepc_wdata_o, 32'd0);
    drive_idle();
    rst_i = 1'b0;
    @(posedge clk); #1;
    check("idle after reset", 32'(busy_o), 32'd0);

    foreach (vecs[i]) run_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset during the first flush cycle: nothing must follow.
    rv = vecs[0];
    trap_i.valid = 1'b1; trap_i.is_interrupt = 1'b0; trap_i.mcause = rv.cause;
    trap_i.pc = rv.pc; trap_i.insn = rv.insn; mtvec_i = rv.mtvec;
    @(posedge clk); #1;
    drive_idle();
    check("rst_flush started", 32'(flush_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("rst_flush outputs cleared", {28'd0, busy_o, flush_o, csr_trap_wr_o, mstatus_trap_o}, 32'd0);
    quiet_cycles(10, act);
    check("rst_flush no resume", 32'(act), 32'd0);

    // Reset while a redirect is pending.
    mret_i = 1'b1; mepc_i = 32'h0000_0ABC;
    @(posedge clk); #1;
    drive_idle();
    guard = 0;
    while (!redirect_valid_o && guard < 20) begin @(posedge clk); #1; guard++; end
    check("rst_redir reached redirect", 32'(redirect_valid_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("rst_redir cleared", {29'd0, busy_o, redirect_valid_o, mstatus_mret_o}, 32'd0);
    check("rst_redir pc cleared", redirect_pc_o, 32'd0);
    quiet_cycles(6, act);
    check("rst_redir no resume", 32'(act), 32'd0);
    run_txn(vecs[1], 1'b0, "post_reset");

    // Randomized transactions with ignored noise on trap/mret while busy.
    for (int n = 0; n < 150; n++) begin
      rv = '{default: '0};
      rv.is_trap = ($urandom_range(0, 3) != 0);
      rv.mret    = 1'($urandom);
      if (!rv.is_trap) rv.mret = 1'b1;
      rv.is_int  = 1'($urandom);
      if (rv.is_int)
        rv.cause = ($urandom_range(0, 3) == 0) ? 31'($urandom) : 31'(2 * $urandom_range(0, 31) + 1);
      else
        rv.cause = 31'($urandom_range(0, 15));
      rv.pc    = $urandom;
      rv.insn  = $urandom;
      rv.addr  = $urandom;
      rv.mtvec = $urandom;
      rv.mepc  = $urandom;
      rv.delay = $urandom_range(0, 6);
      rv = model(rv);
      run_txn(rv, 1'b1, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
